// File: rtl/ram_access_ctrl_if.sv
// Shared cache/SRAM types plus the bundle of arbiter-side and SRAM-side signals
// used by ram_access_ctrl (slave modport) and its environment (master modport).
package caches_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

interface ram_access_ctrl_if #(
  parameter int ADDR_W = 16
);
  import caches_pkg::*;

  logic              ramREN;
  logic              ramWEN;
  word_t             ramaddr;
  word_t             ramstore;
  word_t             ramload;
  ramstate_t         ramstate;
  logic [ADDR_W-1:0] mem_addr;
  word_t             mem_wdata;
  logic              mem_ren;
  logic              mem_wen;
  word_t             mem_rdata;

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore, mem_rdata,
    output ramload, ramstate, mem_addr, mem_wdata, mem_ren, mem_wen
  );

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore, mem_rdata,
    input  ramload, ramstate, mem_addr, mem_wdata, mem_ren, mem_wen
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Fixed-latency SRAM access sequencer between the cache arbiter and a single-port SRAM.
// Define RAM_ERR_CHECK_EN to reject misaligned / out-of-range addresses via the FAULT state.
module ram_access_ctrl
  import caches_pkg::*;
#(
  parameter int LAT    = 2,
  parameter int ADDR_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  ram_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  word_t     addr_q, addr_d;
  word_t     data_q, data_d;
  logic      wr_q, wr_d;
  word_t     ramload_q, ramload_d;
  ramstate_t ramstate_q, ramstate_d;
  logic      mem_ren_q, mem_ren_d;
  logic      mem_wen_q, mem_wen_d;

  logic req_s;
  logic req_wr_s;
  logic mismatch_s;
  logic addr_bad_s;

  function automatic ramstate_t state_to_ramstate(input state_t st);
    ramstate_t rs;
    case (st)
      IDLE:    rs = FREE;
      WAIT:    rs = BUSY;
      DONE:    rs = ACCESS;
      FAULT:   rs = ERROR;
      default: rs = FREE;
    endcase
    return rs;
  endfunction

`ifdef RAM_ERR_CHECK_EN
  function automatic logic addr_invalid(input word_t a);
    word_t hi;
    hi = a >> (ADDR_W + 2);
    return (a[1:0] != 2'b00) || (hi != 32'd0);
  endfunction
`endif

  // Request decode and comparison of live inputs against the latched request
  always_comb begin
    req_s      = bus.ramREN | bus.ramWEN;
    req_wr_s   = bus.ramWEN;
    mismatch_s = (bus.ramaddr != addr_q) || !req_s || (req_wr_s != wr_q);
`ifdef RAM_ERR_CHECK_EN
    addr_bad_s = req_s && addr_invalid(bus.ramaddr);
`else
    addr_bad_s = 1'b0;
`endif
  end

  // Next-state, latch, counter and registered-strobe logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_d      = wr_q;
    mem_ren_d = 1'b0;
    mem_wen_d = 1'b0;
    ramload_d = mem_ren_q ? bus.mem_rdata : ramload_q;

    case (state_q)
      IDLE: begin
        if (addr_bad_s) begin
          state_d = FAULT;
        end else if (req_s) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
          addr_d  = bus.ramaddr;
          data_d  = bus.ramstore;
          wr_d    = req_wr_s;
          // With a single BUSY cycle the strobe must already be scheduled here
          if (CNT_LOAD == 4'd0) begin
            mem_wen_d = req_wr_s;
            mem_ren_d = !req_wr_s;
          end else begin
            mem_wen_d = 1'b0;
            mem_ren_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end

      WAIT: begin
        // The strobe is already on the bus in the exit cycle, so it is committed
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else if (mismatch_s) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            mem_wen_d = wr_q;
            mem_ren_d = !wr_q;
          end else begin
            mem_wen_d = 1'b0;
            mem_ren_d = 1'b0;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      FAULT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    ramstate_d = state_to_ramstate(state_d);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      wr_q       <= 1'b0;
      ramload_q  <= 32'd0;
      ramstate_q <= FREE;
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      ramload_q  <= ramload_d;
      ramstate_q <= ramstate_d;
      mem_ren_q  <= mem_ren_d;
      mem_wen_q  <= mem_wen_d;
    end
  end

  assign bus.ramload   = ramload_q;
  assign bus.ramstate  = ramstate_q;
  assign bus.mem_addr  = addr_q[ADDR_W+1:2];
  assign bus.mem_wdata = data_q;
  assign bus.mem_ren   = mem_ren_q;
  assign bus.mem_wen   = mem_wen_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level model with its own memory image.
module tb_ram_access_ctrl;
  import caches_pkg::*;

  localparam int LAT    = 2;
  localparam int ADDR_W = 16;
  localparam int NOBS   = 64;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   tests = 0;
  int   fails = 0;

  ram_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  ram_access_ctrl #(.LAT(LAT), .ADDR_W(ADDR_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // SRAM environment: power-up pattern until a word is written, combinational read
  logic [31:0] sram    [0:255];
  logic        sram_wr [0:255] = '{default: 1'b0};
  logic [7:0]  rd_idx;
  int          n_ren  = 0;
  int          n_wen  = 0;
  int          n_both = 0;

  function automatic logic [31:0] init_word(input logic [7:0] a);
    if (a == 8'd4) return 32'hDEAD_BEEF;
    else return {8'hA5, a, ~a, 8'h5A};
  endfunction

  always_comb begin
    rd_idx        = bus.mem_addr[7:0];
    bus.mem_rdata = sram_wr[rd_idx] ? sram[rd_idx] : init_word(rd_idx);
  end

  always @(posedge CLK) begin
    if (bus.mem_wen) begin
      sram[bus.mem_addr[7:0]]    <= bus.mem_wdata;
      sram_wr[bus.mem_addr[7:0]] <= 1'b1;
      n_wen <= n_wen + 1;
    end
    if (bus.mem_ren) n_ren <= n_ren + 1;
    if (bus.mem_ren && bus.mem_wen) n_both <= n_both + 1;
  end

  // Reference model state
  logic [31:0] exp_mem [0:255];
  logic [31:0] exp_ramload;

  // Observation buffer, one entry per cycle of a scenario
  ramstate_t         obs_st  [0:NOBS-1];
  logic              obs_ren [0:NOBS-1];
  logic              obs_wen [0:NOBS-1];
  logic [ADDR_W-1:0] obs_ma  [0:NOBS-1];
  logic [31:0]       obs_wd  [0:NOBS-1];
  logic [31:0]       obs_ld  [0:NOBS-1];
  int                ncap;

  function automatic ramstate_t exp_state(input int i);
    if (i == 0) return FREE;
    else if (i <= LAT) return BUSY;
    else if (i == LAT + 1) return ACCESS;
    else return FREE;
  endfunction

  task automatic sample_now();
    if (ncap < NOBS) begin
      obs_st[ncap]  = bus.ramstate;
      obs_ren[ncap] = bus.mem_ren;
      obs_wen[ncap] = bus.mem_wen;
      obs_ma[ncap]  = bus.mem_addr;
      obs_wd[ncap]  = bus.mem_wdata;
      obs_ld[ncap]  = bus.ramload;
      ncap++;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    sample_now();
  endtask

  task automatic set_req(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d);
    bus.ramREN   = ren;
    bus.ramWEN   = wen;
    bus.ramaddr  = a;
    bus.ramstore = d;
  endtask

  // Drives one request held until ACCESS, then released; captures LAT+3 cycles
  task automatic run_txn(input logic ren, input logic wen, input logic [31:0] a, input logic [31:0] d);
    ncap = 0;
    set_req(ren, wen, a, d);
    sample_now();
    repeat (LAT + 1) tick();
    set_req(1'b0, 1'b0, a, d);
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    tests++; if (bus.ramstate !== FREE) begin fails++; $display("FAIL reset_state: got %0d expected %0d", bus.ramstate, FREE); end
    tests++; if (bus.ramload !== 32'd0) begin fails++; $display("FAIL reset_ramload: got %h expected 0", bus.ramload); end
    tests++; if (bus.mem_ren !== 1'b0) begin fails++; $display("FAIL reset_ren: got %b expected 0", bus.mem_ren); end
    tests++; if (bus.mem_wen !== 1'b0) begin fails++; $display("FAIL reset_wen: got %b expected 0", bus.mem_wen); end
    tests++; if (bus.mem_addr !== 16'd0) begin fails++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr); end
    tests++; if (bus.mem_wdata !== 32'd0) begin fails++; $display("FAIL reset_wdata: got %h expected 0", bus.mem_wdata); end
    RST = 1'b0;
    @(posedge CLK);
    #1;
    tests++; if (bus.ramstate !== FREE) begin fails++; $display("FAIL reset_idle: got %0d expected %0d", bus.ramstate, FREE); end
    exp_ramload = 32'd0;
  endtask

  task automatic test_read();
    int r0, w0;
    r0 = n_ren; w0 = n_wen;
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    for (int i = 0; i <= LAT + 2; i++) begin
      tests++; if (obs_st[i] !== exp_state(i)) begin fails++; $display("FAIL rd_state[%0d]: got %0d expected %0d", i, obs_st[i], exp_state(i)); end
      tests++; if (obs_ren[i] !== (i == LAT)) begin fails++; $display("FAIL rd_ren[%0d]: got %b expected %b", i, obs_ren[i], (i == LAT)); end
      tests++; if (obs_wen[i] !== 1'b0) begin fails++; $display("FAIL rd_wen[%0d]: got %b expected 0", i, obs_wen[i]); end
    end
    tests++; if (obs_ma[LAT] !== 16'h0004) begin fails++; $display("FAIL rd_addr: got %h expected 0004", obs_ma[LAT]); end
    tests++; if (obs_ld[LAT+1] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_load: got %h expected deadbeef", obs_ld[LAT+1]); end
    tests++; if (obs_ld[LAT+2] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_load_hold: got %h expected deadbeef", obs_ld[LAT+2]); end
    tests++; if ((n_ren - r0) !== 1 || (n_wen - w0) !== 0) begin fails++; $display("FAIL rd_strobe_count: got ren %0d wen %0d expected 1 0", n_ren - r0, n_wen - w0); end
    exp_ramload = exp_mem[8'd4];
  endtask

  task automatic test_write();
    int w0;
    w0 = n_wen;
    run_txn(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    for (int i = 0; i <= LAT + 2; i++) begin
      tests++; if (obs_st[i] !== exp_state(i)) begin fails++; $display("FAIL wr_state[%0d]: got %0d expected %0d", i, obs_st[i], exp_state(i)); end
      tests++; if (obs_wen[i] !== (i == LAT)) begin fails++; $display("FAIL wr_wen[%0d]: got %b expected %b", i, obs_wen[i], (i == LAT)); end
      tests++; if (obs_ren[i] !== 1'b0) begin fails++; $display("FAIL wr_ren[%0d]: got %b expected 0", i, obs_ren[i]); end
    end
    tests++; if (obs_ma[LAT] !== 16'h0008) begin fails++; $display("FAIL wr_addr: got %h expected 0008", obs_ma[LAT]); end
    tests++; if (obs_wd[LAT] !== 32'h1234_5678) begin fails++; $display("FAIL wr_data: got %h expected 12345678", obs_wd[LAT]); end
    tests++; if (obs_ld[LAT+1] !== exp_ramload) begin fails++; $display("FAIL wr_load_kept: got %h expected %h", obs_ld[LAT+1], exp_ramload); end
    tests++; if ((n_wen - w0) !== 1) begin fails++; $display("FAIL wr_pulses: got %0d expected 1", n_wen - w0); end
    exp_mem[8'd8] = 32'h1234_5678;
  endtask

  task automatic test_abort();
    int r0;
    r0 = n_ren;
    ncap = 0;
    set_req(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    sample_now();
    tick();
    set_req(1'b1, 1'b0, 32'h0000_0044, 32'd0);
    repeat (LAT + 2) tick();
    set_req(1'b0, 1'b0, 32'h0000_0044, 32'd0);
    tick();
    tests++; if (obs_st[1] !== BUSY) begin fails++; $display("FAIL ab_busy: got %0d expected %0d", obs_st[1], BUSY); end
    for (int i = 2; i <= LAT + 4; i++) begin
      tests++; if (obs_st[i] !== exp_state(i - 2)) begin fails++; $display("FAIL ab_state[%0d]: got %0d expected %0d", i, obs_st[i], exp_state(i - 2)); end
    end
    for (int i = 0; i <= LAT + 4; i++) begin
      tests++; if (obs_ren[i] !== (i == LAT + 2) || obs_wen[i] !== 1'b0) begin fails++; $display("FAIL ab_strobe[%0d]: got ren %b wen %b", i, obs_ren[i], obs_wen[i]); end
    end
    tests++; if (obs_ma[LAT+2] !== 16'h0011) begin fails++; $display("FAIL ab_addr: got %h expected 0011", obs_ma[LAT+2]); end
    tests++; if (obs_ld[LAT+3] !== exp_mem[8'h11]) begin fails++; $display("FAIL ab_load: got %h expected %h", obs_ld[LAT+3], exp_mem[8'h11]); end
    tests++; if ((n_ren - r0) !== 1) begin fails++; $display("FAIL ab_count: got %0d expected 1", n_ren - r0); end
    exp_ramload = exp_mem[8'h11];
  endtask

  task automatic test_reset_midflight();
    int r0, w0;
    r0 = n_ren; w0 = n_wen;
    ncap = 0;
    set_req(1'b1, 1'b0, 32'h0000_0080, 32'd0);
    sample_now();
    tick();
    RST = 1'b1;
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    RST = 1'b0;
    repeat (LAT + 1) tick();
    tests++; if (obs_st[1] !== BUSY) begin fails++; $display("FAIL rst_busy: got %0d expected %0d", obs_st[1], BUSY); end
    for (int i = 2; i <= LAT + 3; i++) begin
      tests++; if (obs_st[i] !== FREE) begin fails++; $display("FAIL rst_state[%0d]: got %0d expected %0d", i, obs_st[i], FREE); end
    end
    tests++; if (obs_ld[2] !== 32'd0) begin fails++; $display("FAIL rst_load: got %h expected 0", obs_ld[2]); end
    tests++; if ((n_ren - r0) !== 0 || (n_wen - w0) !== 0) begin fails++; $display("FAIL rst_strobes: got ren %0d wen %0d expected 0 0", n_ren - r0, n_wen - w0); end
    exp_ramload = 32'd0;
  endtask

  task automatic test_both();
    int r0;
    logic [31:0] d;
    r0 = n_ren;
    d  = $urandom;
    run_txn(1'b1, 1'b1, 32'h0000_0030, d);
    tests++; if (obs_wen[LAT] !== 1'b1) begin fails++; $display("FAIL both_wen: got %b expected 1", obs_wen[LAT]); end
    tests++; if (obs_ma[LAT] !== 16'h000C || obs_wd[LAT] !== d) begin fails++; $display("FAIL both_bus: got %h/%h expected 000c/%h", obs_ma[LAT], obs_wd[LAT], d); end
    tests++; if ((n_ren - r0) !== 0) begin fails++; $display("FAIL both_ren: got %0d expected 0", n_ren - r0); end
    tests++; if (obs_st[LAT+1] !== ACCESS) begin fails++; $display("FAIL both_access: got %0d expected %0d", obs_st[LAT+1], ACCESS); end
    exp_mem[8'd12] = d;
    run_txn(1'b1, 1'b0, 32'h0000_0030, 32'd0);
    tests++; if (obs_ld[LAT+1] !== d) begin fails++; $display("FAIL both_readback: got %h expected %h", obs_ld[LAT+1], d); end
    exp_ramload = d;
  endtask

  task automatic test_misaligned();
    int r0, w0;
    r0 = n_ren; w0 = n_wen;
`ifdef RAM_ERR_CHECK_EN
    ncap = 0;
    set_req(1'b1, 1'b0, 32'h0000_0013, 32'd0);
    sample_now();
    tick();
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    repeat (LAT) tick();
    tests++; if (obs_st[1] !== ERROR) begin fails++; $display("FAIL mis_error: got %0d expected %0d", obs_st[1], ERROR); end
    tests++; if (obs_st[2] !== FREE) begin fails++; $display("FAIL mis_free: got %0d expected %0d", obs_st[2], FREE); end
    tests++; if ((n_ren - r0) !== 0 || (n_wen - w0) !== 0) begin fails++; $display("FAIL mis_strobes: got ren %0d wen %0d expected 0 0", n_ren - r0, n_wen - w0); end
`else
    run_txn(1'b1, 1'b0, 32'h0000_0013, 32'd0);
    for (int i = 0; i <= LAT + 2; i++) begin
      tests++; if (obs_st[i] !== exp_state(i)) begin fails++; $display("FAIL mis_state[%0d]: got %0d expected %0d", i, obs_st[i], exp_state(i)); end
    end
    tests++; if (obs_ren[LAT] !== 1'b1 || obs_ma[LAT] !== 16'h0004) begin fails++; $display("FAIL mis_read: got ren %b addr %h expected 1 0004", obs_ren[LAT], obs_ma[LAT]); end
    tests++; if (obs_ld[LAT+1] !== exp_mem[8'd4]) begin fails++; $display("FAIL mis_load: got %h expected %h", obs_ld[LAT+1], exp_mem[8'd4]); end
    tests++; if ((n_ren - r0) !== 1 || (n_wen - w0) !== 0) begin fails++; $display("FAIL mis_count: got ren %0d wen %0d expected 1 0", n_ren - r0, n_wen - w0); end
    exp_ramload = exp_mem[8'd4];
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] wa, wb;
    int base;
    wa = 8'($urandom_range(0, 255));
    wb = 8'($urandom_range(0, 255));
    base = LAT + 2;
    ncap = 0;
    set_req(1'b1, 1'b0, {22'd0, wa, 2'b00}, 32'd0);
    sample_now();
    repeat (LAT + 1) tick();
    set_req(1'b1, 1'b0, {22'd0, wb, 2'b00}, 32'd0);
    repeat (LAT + 2) tick();
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    for (int i = 0; i < base + LAT + 3; i++) begin
      if (i < base) begin
        tests++; if (obs_st[i] !== exp_state(i)) begin fails++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, obs_st[i], exp_state(i)); end
      end else begin
        tests++; if (obs_st[i] !== exp_state(i - base)) begin fails++; $display("FAIL b2b_state[%0d]: got %0d expected %0d", i, obs_st[i], exp_state(i - base)); end
      end
    end
    tests++; if (obs_ld[LAT+1] !== exp_mem[wa]) begin fails++; $display("FAIL b2b_load_a: got %h expected %h", obs_ld[LAT+1], exp_mem[wa]); end
    tests++; if (obs_ld[base+LAT+1] !== exp_mem[wb]) begin fails++; $display("FAIL b2b_load_b: got %h expected %h", obs_ld[base+LAT+1], exp_mem[wb]); end
    exp_ramload = exp_mem[wb];
  endtask

  task automatic test_random();
    int kind, gap;
    logic [7:0]  w;
    logic [31:0] d;
    logic        is_wr;
    for (int n = 0; n < 40; n++) begin
      kind  = $urandom_range(0, 2);
      gap   = $urandom_range(0, 2);
      w     = 8'($urandom_range(0, 255));
      d     = $urandom;
      is_wr = (kind != 0);
      repeat (gap) begin @(posedge CLK); #1; end
      run_txn((kind != 1), is_wr, {22'd0, w, 2'b00}, d);
      for (int i = 0; i <= LAT + 2; i++) begin
        tests++; if (obs_st[i] !== exp_state(i)) begin fails++; $display("FAIL rnd%0d_state[%0d]: got %0d expected %0d", n, i, obs_st[i], exp_state(i)); end
        tests++; if (obs_ren[i] !== (i == LAT && !is_wr) || obs_wen[i] !== (i == LAT && is_wr)) begin fails++; $display("FAIL rnd%0d_strobe[%0d]: got ren %b wen %b (write=%b)", n, i, obs_ren[i], obs_wen[i], is_wr); end
      end
      tests++; if (obs_ma[LAT] !== {8'd0, w}) begin fails++; $display("FAIL rnd%0d_addr: got %h expected %h", n, obs_ma[LAT], {8'd0, w}); end
      if (is_wr) begin
        tests++; if (obs_wd[LAT] !== d) begin fails++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, obs_wd[LAT], d); end
        exp_mem[w] = d;
      end else begin
        exp_ramload = exp_mem[w];
      end
      tests++; if (obs_ld[LAT+1] !== exp_ramload) begin fails++; $display("FAIL rnd%0d_load: got %h expected %h", n, obs_ld[LAT+1], exp_ramload); end
    end
    tests++; if (n_both !== 0) begin fails++; $display("FAIL strobe_overlap: got %0d expected 0", n_both); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(8'(i));
    exp_ramload = 32'd0;
    set_req(1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_read();
    test_write();
    test_abort();
    test_reset_midflight();
    test_both();
    test_misaligned();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
